ir_encoder_tx: RTL and testbench

Transmit-side counterpart of the IR button decoder: accepts a 4-bit button code over a valid/ready handshake, maps it to the 16-bit raw IR word, and serializes that word onto a single IR envelope line using pulse-distance encoding. Sits between the game/controller logic and the external IR LED driver; the carrier is modulated downstream. The raw words are exactly those the receive-side decoder maps back to button codes, so a loopback yields the original code.

---
 rtl/ir_encoder_tx_pkg.sv | 49 ++++
 rtl/ir_encoder_tx_if.sv | 9 +
 rtl/ir_encoder_tx_tick_gen.sv | 26 ++
 rtl/ir_encoder_tx.sv | 99 +++++++++
 tb/tb_ir_encoder_tx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ir_encoder_tx_pkg.sv
// ir_pkg: button codes, raw IR words shared with the decoder, transmitter states
// and per-state durations in T units.
package ir_pkg;
   typedef enum logic [3:0] {
      BTN_B     = 4'b0001,
      BTN_Y     = 4'b0010,
      BTN_UP    = 4'b0101,
      BTN_DOWN  = 4'b0110,
      BTN_LEFT  = 4'b0111,
      BTN_RIGHT = 4'b1000,
      BTN_A     = 4'b1001,
      BTN_X     = 4'b1010
   } btn_code_t;

   localparam logic [15:0] RAW_B     = 16'h0A0B;
   localparam logic [15:0] RAW_Y     = 16'h0A02;
   localparam logic [15:0] RAW_UP    = 16'h0A04;
   localparam logic [15:0] RAW_DOWN  = 16'h0A06;
   localparam logic [15:0] RAW_LEFT  = 16'h0A08;
   localparam logic [15:0] RAW_RIGHT = 16'h0A10;
   localparam logic [15:0] RAW_A     = 16'h0A0A;
   localparam logic [15:0] RAW_X     = 16'h0A12;

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
   } tx_state_t;

   localparam int LEAD_MARK_T  = 16;
   localparam int LEAD_SPACE_T = 8;
   localparam int BIT_MARK_T   = 1;
   localparam int ZERO_SPACE_T = 1;
   localparam int ONE_SPACE_T  = 3;
   localparam int STOP_T       = 1;

   // Returns {mapped, raw_word}; mapped=0 for codes outside the button set.
   function automatic logic [16:0] map_code(input logic [3:0] code);
      case (code)
         BTN_B:     return {1'b1, RAW_B};
         BTN_Y:     return {1'b1, RAW_Y};
         BTN_UP:    return {1'b1, RAW_UP};
         BTN_DOWN:  return {1'b1, RAW_DOWN};
         BTN_LEFT:  return {1'b1, RAW_LEFT};
         BTN_RIGHT: return {1'b1, RAW_RIGHT};
         BTN_A:     return {1'b1, RAW_A};
         BTN_X:     return {1'b1, RAW_X};
         default:   return 17'h0;
      endcase
   endfunction
endpackage

// File: rtl/ir_encoder_tx_if.sv
// ir_encoder_tx_if: button request handshake between controller logic and the IR transmitter.
interface ir_encoder_tx_if;
   import ir_pkg::*;
   logic [3:0] btn_code;
   logic       btn_valid;
   logic       btn_ready;
   modport master (output btn_code, btn_valid, input btn_ready);
   modport slave (input btn_code, btn_valid, output btn_ready);
endinterface

// File: rtl/ir_encoder_tx_tick_gen.sv
// ir_tick_gen: one-cycle tick every TICK_CYCLES clocks, realigned on frame start;
// pre_tick flags the cycle before tick.
module ir_tick_gen #(
   parameter int TICK_CYCLES = 28125
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic tick,
   output logic pre_tick
);
   localparam int CW = $clog2(TICK_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick = cnt_q == CW'(TICK_CYCLES - 1);
      pre_tick = cnt_q == CW'(TICK_CYCLES - 2);
      cnt_d = (start || tick) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ir_encoder_tx.sv
// ir_encoder_tx: maps a button code to its raw IR word and sends it as a
// pulse-distance envelope (lead, 16 bits MSB first, stop mark, inter-frame gap).
module ir_encoder_tx
   import ir_pkg::*;
#(
   parameter int TICK_CYCLES = 28125,
   parameter int GAP_T = 40
) (
   input  logic            clk,
   input  logic            rst_n,
   ir_encoder_tx_if.slave  btn,
   output logic            ir_out,
   output logic            busy,
   output logic [15:0]     raw_word,
   output logic            frame_done,
   output logic            code_err
);
   tx_state_t   state_q, state_d;
   logic [5:0]  unit_q, unit_d;
   logic [3:0]  bit_q, bit_d;
   logic [15:0] word_q, word_d;
   logic        ir_q, ir_d, done_q, done_d, err_q, err_d;
   logic        tick, pre_tick, start, fin;
   logic [16:0] map;
   logic [5:0]  dur;

   ir_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .tick(tick),
      .pre_tick(pre_tick)
   );

   // GAP leaves one cycle early so the IDLE accept cycle completes the GAP_T*T space.
   always_comb begin
      map = map_code(btn.btn_code);
      start = state_q == IDLE && btn.btn_valid && map[16];
      dur = state_q == LEAD_MARK  ? 6'(LEAD_MARK_T) :
            state_q == LEAD_SPACE ? 6'(LEAD_SPACE_T) :
            state_q == BIT_MARK   ? 6'(BIT_MARK_T) :
            state_q == BIT_SPACE  ? (word_q[bit_q] ? 6'(ONE_SPACE_T) : 6'(ZERO_SPACE_T)) :
                                    6'(STOP_T);
      fin = state_q == GAP ? (pre_tick && unit_q == 6'(GAP_T - 1)) : (tick && unit_q == dur - 6'd1);
      state_d = state_q;
      unit_d = fin ? 6'd0 : (tick && state_q != IDLE) ? unit_q + 6'd1 : unit_q;
      bit_d = bit_q;
      word_d = start ? map[15:0] : word_q;
      done_d = 1'b0;
      err_d = state_q == IDLE && btn.btn_valid && !map[16];
      case (state_q)
         IDLE: if (start) begin
            state_d = LEAD_MARK;
            bit_d = 4'd15;
         end
         LEAD_MARK:  if (fin) state_d = LEAD_SPACE;
         LEAD_SPACE: if (fin) state_d = BIT_MARK;
         BIT_MARK:   if (fin) state_d = BIT_SPACE;
         BIT_SPACE:  if (fin) begin
            state_d = bit_q == 4'd0 ? STOP_MARK : BIT_MARK;
            bit_d = bit_q - 4'd1;
         end
         STOP_MARK:  if (fin) state_d = GAP;
         GAP:        if (fin) begin
            state_d = IDLE;
            done_d = 1'b1;
         end
         default:    state_d = IDLE;
      endcase
      ir_d = state_d == LEAD_MARK || state_d == BIT_MARK || state_d == STOP_MARK;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         unit_q <= '0;
         bit_q <= '0;
         word_q <= '0;
         ir_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         unit_q <= unit_d;
         bit_q <= bit_d;
         word_q <= word_d;
         ir_q <= ir_d;
         done_q <= done_d;
         err_q <= err_d;
      end
   end

   assign btn.btn_ready = state_q == IDLE;
   assign busy = state_q != IDLE;
   assign ir_out = ir_q;
   assign raw_word = word_q;
   assign frame_done = done_q;
   assign code_err = err_q;
endmodule

// File: tb/tb_ir_encoder_tx.sv
// tb_ir_encoder_tx: directed checks of envelope timing, handshake, unmapped codes,
// mid-frame reset and a receive-side loopback of every button.
module tb_ir_encoder_tx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ir_out, busy, frame_done, code_err;
   logic [15:0] raw_word;
   int          n_assert = 0;
   int          n_fail = 0;

   ir_encoder_tx_if bif ();

   ir_encoder_tx #(.TICK_CYCLES(4), .GAP_T(40)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn(bif),
      .ir_out(ir_out),
      .busy(busy),
      .raw_word(raw_word),
      .frame_done(frame_done),
      .code_err(code_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (ir_out === lvl && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Decodes one envelope; returns at the negedge where frame_done is seen.
   task automatic recv(input string tag, output logic [15:0] w, output int total);
      int n, t, bad;
      w = '0;
      bad = 0;
      t = 0;
      total = 0;
      while (ir_out !== 1'b1 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check({tag, " start"}, 32'(t < 500), 1);
      run_len(1'b1, n); total += n;
      check({tag, " lead mark"}, n, 64);
      run_len(1'b0, n); total += n;
      check({tag, " lead space"}, n, 32);
      for (int i = 15; i >= 0; i--) begin
         run_len(1'b1, n); total += n;
         if (n != 4) bad++;
         run_len(1'b0, n); total += n;
         if (n == 12) w[i] = 1'b1;
         else if (n != 4) bad++;
      end
      check({tag, " bit timing errors"}, bad, 0);
      run_len(1'b1, n); total += n;
      total -= n;
      total += 4;
      check({tag, " stop mark"}, n, 4);
      t = 1;
      while (frame_done !== 1'b1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      check({tag, " gap to frame_done"}, t, 160);
   endtask

   task automatic send(input logic [3:0] c);
      bif.btn_code = c;
      bif.btn_valid = 1'b1;
      @(negedge clk);
      bif.btn_valid = 1'b0;
   endtask

   function automatic logic [3:0] word2code(input logic [15:0] w);
      case (w)
         16'h0A0B: return 4'b0001;
         16'h0A02: return 4'b0010;
         16'h0A04: return 4'b0101;
         16'h0A06: return 4'b0110;
         16'h0A08: return 4'b0111;
         16'h0A10: return 4'b1000;
         16'h0A0A: return 4'b1001;
         16'h0A12: return 4'b1010;
         default:  return 4'b0000;
      endcase
   endfunction

   initial begin
      logic [15:0] w;
      logic [3:0]  codes [8];
      int          total, rises, fd, ones;
      logic        prev;
      codes = '{4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};
      bif.btn_code = 4'h0;
      bif.btn_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset ir_out", ir_out, 0);
      check("reset busy", busy, 0);
      check("reset btn_ready", bif.btn_ready, 1);
      check("reset raw_word", raw_word, 16'h0000);
      check("reset frame_done", frame_done, 0);
      check("reset code_err", code_err, 0);

      send(4'b0001);
      check("B accept ir_out", ir_out, 1);
      check("B accept busy", busy, 1);
      check("B accept btn_ready", bif.btn_ready, 0);
      check("B raw_word", raw_word, 16'h0A0B);
      recv("B", w, total);
      check("B decoded word", w, 16'h0A0B);
      check("B frame length", total, 268);
      check("B btn_ready at frame_done", bif.btn_ready, 1);
      @(negedge clk);
      check("B frame_done one cycle", frame_done, 0);

      send(4'b1111);
      check("unmapped code_err", code_err, 1);
      check("unmapped busy", busy, 0);
      check("unmapped ir_out", ir_out, 0);
      check("unmapped raw_word", raw_word, 16'h0A0B);
      @(negedge clk);
      check("unmapped code_err one cycle", code_err, 0);
      check("unmapped still idle", bif.btn_ready, 1);

      bif.btn_code = 4'b0101;
      bif.btn_valid = 1'b1;
      @(negedge clk);
      bif.btn_code = 4'b1000;
      check("UP raw_word", raw_word, 16'h0A04);
      recv("UP", w, total);
      check("UP decoded word", w, 16'h0A04);
      check("UP raw_word at frame_done", raw_word, 16'h0A04);
      @(negedge clk);
      bif.btn_valid = 1'b0;
      check("RIGHT back-to-back lead", ir_out, 1);
      check("RIGHT raw_word", raw_word, 16'h0A10);
      recv("RIGHT", w, total);
      check("RIGHT decoded word", w, 16'h0A10);
      @(negedge clk);

      send(4'b1010);
      prev = 1'b1;
      rises = 1;
      for (int k = 0; k < 1000 && rises < 10; k++) begin
         @(negedge clk);
         if (ir_out && !prev) rises++;
         prev = ir_out;
      end
      check("X reached bit 7", rises, 10);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid-reset ir_out", ir_out, 0);
      check("mid-reset btn_ready", bif.btn_ready, 1);
      check("mid-reset raw_word", raw_word, 16'h0000);
      rst_n = 1'b1;
      fd = 0;
      ones = 0;
      repeat (400) begin
         @(negedge clk);
         if (frame_done) fd++;
         if (ir_out) ones++;
      end
      check("aborted frame_done", fd, 0);
      check("aborted ir_out quiet", ones, 0);
      send(4'b1001);
      check("A raw_word", raw_word, 16'h0A0A);
      recv("A", w, total);
      check("A decoded word", w, 16'h0A0A);
      @(negedge clk);

      foreach (codes[i]) begin
         send(codes[i]);
         recv("loop", w, total);
         check($sformatf("loopback code %0d", codes[i]), word2code(w), codes[i]);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
